// File: rtl/encoder_pipeline_sequencer.sv
// Sequencer for the 3-stage arithmetic-encoder pipeline.
// It valid-gates the register enables and frames each symbol stream with clear, drain and flush phases.
module encoder_pipeline_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 general_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 en_1_2,
  output logic                 en_2_3,
  output logic                 en_final,
  output logic                 enc_clear,
  output logic                 flush_req,
  input  logic                 flush_ack,
  output logic                 frame_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sym_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r;
  state_t                 state_s;
  logic                   v1_r;
  logic                   v2_r;
  logic                   v3_r;
  logic                   flush_req_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   advance_s;
  logic                   in_ready_s;
  logic                   fire_s;

  // Global stall only when a final word is pending and not taken.
  assign advance_s  = !v3_r || out_ready;
  assign in_ready_s = advance_s && (state_r == RUN);
  assign fire_s     = in_valid && in_ready_s;

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CLEAR;
        else       state_s = IDLE;
      end
      CLEAR: state_s = RUN;
      RUN: begin
        if (fire_s && in_last) state_s = DRAIN;
        else                   state_s = RUN;
      end
      DRAIN: begin
        if (!v1_r && !v2_r && !v3_r) state_s = FLUSH;
        else                         state_s = DRAIN;
      end
      FLUSH: begin
        if (flush_ack) state_s = DONE;
        else           state_s = FLUSH;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered flush request.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      flush_req_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      flush_req_r <= (state_s == FLUSH);
    end
  end

  // Pipeline valid bits: shift on advance, hold under stall.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
    end else if (advance_s) begin
      v1_r <= fire_s;
      v2_r <= v1_r;
      v3_r <= v2_r;
    end else begin
      v1_r <= v1_r;
      v2_r <= v2_r;
      v3_r <= v3_r;
    end
  end

  // Saturating per-frame symbol counter, zeroed while clearing the encoder.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (state_r == CLEAR) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (fire_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = v3_r;
  assign en_1_2     = fire_s;
  assign en_2_3     = advance_s && v1_r;
  assign en_final   = advance_s && v2_r;
  assign enc_clear  = (state_r == CLEAR);
  assign flush_req  = flush_req_r;
  assign frame_done = (state_r == DONE);
  assign busy       = (state_r != IDLE);
  assign sym_count  = cnt_r;

endmodule

// File: tb/tb_encoder_pipeline_sequencer.sv
// Directed bench for encoder_pipeline_sequencer; a fire-time scoreboard checks output order and latency.
module tb_encoder_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic        en_1_2;
  logic        en_2_3;
  logic        en_final;
  logic        enc_clear;
  logic        flush_req;
  logic        flush_ack;
  logic        frame_done;
  logic        busy;
  logic [15:0] sym_count;

  logic        in_ready_2;
  logic        out_valid_2;
  logic        en_1_2_2;
  logic        en_2_3_2;
  logic        en_final_2;
  logic        enc_clear_2;
  logic        flush_req_2;
  logic        frame_done_2;
  logic        busy_2;
  logic [1:0]  sym_count_2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pops = 0;
  int fb_loads = 0;
  int mon_lat;
  int q[$];
  bit strict_lat = 1'b0;

  encoder_pipeline_sequencer #(.CNT_WIDTH(16)) dut (
    .general_clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .en_1_2(en_1_2),
    .en_2_3(en_2_3), .en_final(en_final), .enc_clear(enc_clear), .flush_req(flush_req),
    .flush_ack(flush_ack), .frame_done(frame_done), .busy(busy), .sym_count(sym_count)
  );

  encoder_pipeline_sequencer #(.CNT_WIDTH(2)) dut_sat (
    .general_clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_2), .out_ready(out_ready), .out_valid(out_valid_2), .en_1_2(en_1_2_2),
    .en_2_3(en_2_3_2), .en_final(en_final_2), .enc_clear(enc_clear_2), .flush_req(flush_req_2),
    .flush_ack(flush_ack), .frame_done(frame_done_2), .busy(busy_2), .sym_count(sym_count_2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en_2_3) fb_loads <= fb_loads + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push fire cycle on accept, pop and check latency on output handshake.
  always @(negedge clk) begin
    if (reset) begin
      if (in_valid && in_ready) q.push_back(cyc);
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          mon_lat = cyc - q.pop_front();
          pops++;
          if (strict_lat) check("latency", 32'(mon_lat), 32'd3);
          else            check("latency_min", 32'(mon_lat >= 3), 32'd1);
        end
      end
    end
  end

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    mid();
    cyc_step();
    start = 1'b0;
    mid();
    check("clear_pulse", 32'(enc_clear), 32'd1);
    check("clear_no_en", 32'({en_1_2, en_2_3, en_final}), 32'd0);
    check("clear_in_ready", 32'(in_ready), 32'd0);
    cyc_step();
  endtask

  task automatic send(input logic last);
    in_valid = 1'b1;
    in_last  = last;
    mid();
    check("send_in_ready", 32'(in_ready), 32'd1);
    check("send_en_1_2", 32'(en_1_2), 32'd1);
    cyc_step();
  endtask

  task automatic finish_frame(input int hold);
    int n = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mid();
    while (!flush_req && n < 40) begin
      cyc_step();
      mid();
      n++;
    end
    check("flush_req_reached", 32'(flush_req), 32'd1);
    for (int i = 0; i < hold; i++) begin
      cyc_step();
      mid();
      check("flush_req_hold", 32'(flush_req), 32'd1);
      check("no_early_done", 32'(frame_done), 32'd0);
    end
    flush_ack = 1'b1;
    check("flush_busy", 32'(busy), 32'd1);
    cyc_step();
    flush_ack = 1'b0;
    mid();
    check("frame_done", 32'(frame_done), 32'd1);
    check("flush_req_drop", 32'(flush_req), 32'd0);
    cyc_step();
    mid();
    check("frame_done_1cyc", 32'(frame_done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    cyc_step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int loads0;
    reset = 1'b0; start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; flush_ack = 1'b0;

    // 1: reset state, start ignored while reset low
    repeat (3) @(posedge clk);
    #1;
    mid();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    check("rst_flush_req", 32'(flush_req), 32'd0);
    check("rst_enc_clear", 32'(enc_clear), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    cyc_step();
    mid();
    check("post_rst_idle", 32'(busy), 32'd0);
    cyc_step();

    // 2: five back-to-back symbols
    pops = 0; strict_lat = 1'b1;
    start_frame();
    for (int i = 0; i < 5; i++) send(i == 4);
    in_valid = 1'b0; in_last = 1'b0;
    mid();
    check("t2_drain_in_ready", 32'(in_ready), 32'd0);
    check("t2_drain_en_1_2", 32'(en_1_2), 32'd0);
    cyc_step();
    finish_frame(0);
    check("t2_sym_count", 32'(sym_count), 32'd5);
    check("t2_sat_count", 32'(sym_count_2), 32'd3);
    check("t2_outputs", 32'(pops), 32'd5);
    check("t2_sb_empty", 32'(q.size()), 32'd0);

    // 3: bubble slot must not load stage 2/3
    pops = 0;
    start_frame();
    loads0 = fb_loads;
    in_valid = 1'b1; in_last = 1'b0;
    mid(); check("t3_en12_a", 32'(en_1_2), 32'd1); cyc_step();
    in_valid = 1'b0;
    mid(); check("t3_en12_b", 32'(en_1_2), 32'd0); check("t3_en23_a", 32'(en_2_3), 32'd1); cyc_step();
    in_valid = 1'b1; in_last = 1'b1;
    mid();
    check("t3_en12_c", 32'(en_1_2), 32'd1);
    check("t3_en23_b", 32'(en_2_3), 32'd0);
    check("t3_enf_a", 32'(en_final), 32'd1);
    cyc_step();
    in_valid = 1'b0; in_last = 1'b0;
    mid();
    check("t3_en23_c", 32'(en_2_3), 32'd1);
    check("t3_enf_b", 32'(en_final), 32'd0);
    check("t3_drain_ready", 32'(in_ready), 32'd0);
    cyc_step();
    mid(); check("t3_en23_d", 32'(en_2_3), 32'd0); check("t3_enf_c", 32'(en_final), 32'd1); cyc_step();
    finish_frame(0);
    check("t3_fb_loads", 32'(fb_loads - loads0), 32'd2);
    check("t3_outputs", 32'(pops), 32'd2);

    // 4: backpressure for 4 cycles with the final word pending
    pops = 0; strict_lat = 1'b0;
    start_frame();
    for (int i = 0; i < 3; i++) send(1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t4_stall_ready", 32'(in_ready), 32'd0);
      check("t4_stall_en", 32'({en_1_2, en_2_3, en_final}), 32'd0);
      check("t4_stall_valid", 32'(out_valid), 32'd1);
      cyc_step();
    end
    out_ready = 1'b1;
    send(1'b0);
    send(1'b1);
    finish_frame(0);
    check("t4_outputs", 32'(pops), 32'd5);
    check("t4_sb_empty", 32'(q.size()), 32'd0);
    check("t4_sym_count", 32'(sym_count), 32'd5);

    // 5: start and flush_ack in RUN ignored; ack held low in FLUSH
    pops = 0; strict_lat = 1'b1;
    start_frame();
    start = 1'b1; flush_ack = 1'b1; in_valid = 1'b0;
    mid();
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_flush_req_a", 32'(flush_req), 32'd0);
    cyc_step();
    start = 1'b0; flush_ack = 1'b0;
    mid();
    check("t5_no_reclear", 32'(enc_clear), 32'd0);
    check("t5_flush_req_b", 32'(flush_req), 32'd0);
    check("t5_still_run", 32'(in_ready), 32'd1);
    cyc_step();
    send(1'b1);
    finish_frame(10);
    check("t5_outputs", 32'(pops), 32'd1);

    // 6a: counter saturation in the narrow instance
    pops = 0;
    start_frame();
    for (int i = 0; i < 6; i++) send(i == 5);
    finish_frame(0);
    check("t6_sym_count", 32'(sym_count), 32'd6);
    check("t6_sat_count", 32'(sym_count_2), 32'd3);
    check("t6_outputs", 32'(pops), 32'd6);

    // 6b: reset mid-frame with v1=v2=1
    start_frame();
    send(1'b0);
    send(1'b0);
    in_valid = 1'b0;
    mid();
    check("t6_v1_set", 32'(en_2_3), 32'd1);
    check("t6_v2_set", 32'(en_final), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_en", 32'({en_1_2, en_2_3, en_final}), 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_count", 32'(sym_count), 32'd0);
    check("t6_rst_done", 32'(frame_done), 32'd0);
    q.delete();
    cyc_step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("t6_no_frame_done", 32'(frame_done), 32'd0);
      check("t6_no_out_valid", 32'(out_valid), 32'd0);
      check("t6_idle", 32'(busy), 32'd0);
      cyc_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
